// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, BCD digit type and digit limit for stopwatch_bcd.
package stopwatch_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
endpackage

// File: rtl/stopwatch_bcd_edge_sync.sv
// edge_sync: multi-flop synchroniser for an asynchronous input plus rising-edge pulse.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_in,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], async_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise_pulse = sync[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: BCD stopwatch counting synchronised slow_in rising edges under start/stop/clear.
// Optional lap capture register enabled by STOPWATCH_LAP_EN.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock_in,
    input  logic                  reset,
    input  logic                  slow_in,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  running,
    output logic                  overflow,
    output logic                  tick_out
`ifdef STOPWATCH_LAP_EN
    ,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   lap_out
`endif
);
    sw_state_t           state;
    sw_state_t           state_nx;
    logic [4*DIGITS-1:0] inc;
    logic                wrap;
    logic                count_en;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock_in  (clock_in),
        .reset     (reset),
        .async_in  (slow_in),
        .rise_pulse(tick_out)
    );

    // Ripple the +1 through the digits; wrap ends high only when every digit was 9.
    always_comb begin
        inc  = bcd_out;
        wrap = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (wrap) begin
                if (bcd_out[4*i +: 4] == BCD_MAX) begin
                    inc[4*i +: 4] = 4'd0;
                end else begin
                    inc[4*i +: 4] = bcd_out[4*i +: 4] + 4'd1;
                    wrap          = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_nx = clear ? IDLE
                 : stop  ? ((state == IDLE) ? IDLE : PAUSE)
                 : (start && state != RUN) ? RUN
                 : state;
        count_en = (state == RUN) && !stop && !clear && tick_out;
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state    <= IDLE;
            running  <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            state   <= state_nx;
            running <= (state_nx == RUN);
            if (clear) begin
                bcd_out  <= '0;
                overflow <= 1'b0;
            end else if (count_en) begin
                bcd_out <= inc;
                if (wrap) overflow <= 1'b1;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clock_in) begin
        if (reset || clear) lap_out <= '0;
        else if (lap && state == RUN) lap_out <= bcd_out;
    end
`endif
endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb_stopwatch_bcd: directed self-checking bench for stopwatch_bcd (4-digit and 2-digit instances).
module tb_stopwatch_bcd;
    logic        clock_in = 1'b0;
    logic        reset = 1'b1, slow_in = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic        lap = 1'b0;
    logic [15:0] bcd_out;
    logic [7:0]  bcd2;
    logic        running, overflow, tick_out, running2, overflow2, tick2;
    logic [15:0] lap_out;
    logic [7:0]  lap2;
    int          n_chk = 0, n_err = 0;
    logic        got;

    always #5 clock_in = ~clock_in;

    stopwatch_bcd #(.DIGITS(4), .SYNC_STAGES(2)) dut (
        .clock_in(clock_in), .reset(reset), .slow_in(slow_in), .start(start), .stop(stop),
        .clear(clear), .bcd_out(bcd_out), .running(running), .overflow(overflow),
        .tick_out(tick_out)
`ifdef STOPWATCH_LAP_EN
        , .lap(lap), .lap_out(lap_out)
`endif
    );

    stopwatch_bcd #(.DIGITS(2), .SYNC_STAGES(2)) dut2 (
        .clock_in(clock_in), .reset(reset), .slow_in(slow_in), .start(start), .stop(stop),
        .clear(clear), .bcd_out(bcd2), .running(running2), .overflow(overflow2),
        .tick_out(tick2)
`ifdef STOPWATCH_LAP_EN
        , .lap(lap), .lap_out(lap2)
`endif
    );

    task automatic cyc();
        @(posedge clock_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic periods(input int k);
        for (int p = 0; p < k; p++) begin
            slow_in = 1'b1;
            repeat (4) cyc();
            slow_in = 1'b0;
            repeat (4) cyc();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; cyc(); clear = 1'b0;
    endtask

    // Raise slow_in, wait for the tick cycle, then hold sel (0 stop, 1 start, 2 clear) for that edge.
    task automatic tick_with(input int sel);
        got = 1'b0;
        slow_in = 1'b1;
        for (int w = 0; w < 8 && !got; w++) begin
            cyc();
            got = tick_out;
        end
        chk("tick_seen", {31'd0, got}, 32'd1);
        if (sel == 0) stop = 1'b1;
        else if (sel == 1) start = 1'b1;
        else clear = 1'b1;
        cyc();
        stop = 1'b0; start = 1'b0; clear = 1'b0;
        repeat (3) cyc();
        slow_in = 1'b0;
        repeat (4) cyc();
    endtask

    initial begin
        repeat (2) cyc();
        reset = 1'b0;
        chk("rst_bcd", {16'd0, bcd_out}, 32'h0);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_tick", {31'd0, tick_out}, 32'd0);
        periods(2);
        chk("idle_hold", {16'd0, bcd_out}, 32'h0);
        pulse_start();
        chk("start_running", {31'd0, running}, 32'd1);
        periods(12);
        chk("count12", {16'd0, bcd_out}, 32'h0012);
        chk("count12_run", {31'd0, running}, 32'd1);
        chk("count12_ovf", {31'd0, overflow}, 32'd0);

        pulse_clear();
        chk("clear_bcd", {16'd0, bcd_out}, 32'h0);
        chk("clear_idle", {31'd0, running}, 32'd0);
        pulse_start();
        periods(5);
        chk("count5", {16'd0, bcd_out}, 32'h0005);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("pause_running", {31'd0, running}, 32'd0);
        periods(3);
        chk("pause_hold", {16'd0, bcd_out}, 32'h0005);
        pulse_start();
        periods(2);
        chk("resume7", {16'd0, bcd_out}, 32'h0007);
        chk("resume_running", {31'd0, running}, 32'd1);

        pulse_clear();
        pulse_start();
        periods(41);
        chk("count41", {16'd0, bcd_out}, 32'h0041);
        tick_with(0);
        chk("stop_tick_bcd", {16'd0, bcd_out}, 32'h0041);
        chk("stop_tick_pause", {31'd0, running}, 32'd0);
        tick_with(1);
        chk("start_tick_bcd", {16'd0, bcd_out}, 32'h0041);
        chk("start_tick_run", {31'd0, running}, 32'd1);
        periods(1);
        chk("count42", {16'd0, bcd_out}, 32'h0042);

        pulse_clear();
        pulse_start();
        periods(99);
        chk("d2_99", {24'd0, bcd2}, 32'h99);
        chk("d4_99", {16'd0, bcd_out}, 32'h0099);
        tick_with(2);
        chk("clr_wrap_bcd2", {24'd0, bcd2}, 32'h0);
        chk("clr_wrap_ovf2", {31'd0, overflow2}, 32'd0);
        chk("clr_wrap_bcd", {16'd0, bcd_out}, 32'h0);
        pulse_start();
        periods(99);
        chk("d2_99b_ovf", {31'd0, overflow2}, 32'd0);
        periods(1);
        chk("wrap_bcd2", {24'd0, bcd2}, 32'h00);
        chk("wrap_ovf2", {31'd0, overflow2}, 32'd1);
        chk("carry_bcd", {16'd0, bcd_out}, 32'h0100);
        chk("carry_ovf", {31'd0, overflow}, 32'd0);
        periods(3);
        chk("ovf_sticky", {31'd0, overflow2}, 32'd1);
        chk("after_wrap2", {24'd0, bcd2}, 32'h03);
        pulse_clear();
        chk("clr_ovf2", {31'd0, overflow2}, 32'd0);
        chk("clr_idle2", {31'd0, running2}, 32'd0);

        pulse_start();
        periods(333);
        chk("count333", {16'd0, bcd_out}, 32'h0333);
        chk("ovf2_333", {31'd0, overflow2}, 32'd1);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("mid_rst_bcd", {16'd0, bcd_out}, 32'h0);
        chk("mid_rst_run", {31'd0, running}, 32'd0);
        chk("mid_rst_ovf2", {31'd0, overflow2}, 32'd0);
        chk("mid_rst_bcd2", {24'd0, bcd2}, 32'h0);
        periods(2);
        chk("rst_ignore", {16'd0, bcd_out}, 32'h0);
        pulse_start();
        periods(1);
        chk("rst_restart", {16'd0, bcd_out}, 32'h0001);

`ifdef STOPWATCH_LAP_EN
        pulse_clear();
        chk("lap_clear", {16'd0, lap_out}, 32'h0);
        pulse_start();
        periods(20);
        lap = 1'b1; cyc(); lap = 1'b0;
        chk("lap_cap", {16'd0, lap_out}, 32'h0020);
        periods(3);
        chk("lap_hold", {16'd0, lap_out}, 32'h0020);
        chk("lap_advance", {16'd0, bcd_out}, 32'h0023);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
